flipflop_out_cell: RTL and testbench
====================================

Name: flipflop_out_cell

Overview:
- Single-bit set/clear output latch driving one physical output pin (`bit`) from two interface control strobes (`set`, `reset`).
- Sits between the host interface register bank and the pin, as a plugin output.
- Optional input synchroniser stages for controls originating in another domain.
- Fully synchronous to `clk`, with a synchronous active-low system reset `rst_n`.

Parameters:
- DEFAULT, 0: value of `bit` after system reset and at power-up. 0 or 1.
- SYNC_STAGES, 0: number of flop stages inserted on `set` and `reset` before the latch logic. Legal values 0..3; 0 means direct use.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous active-low system reset; sampled on the rising edge of `clk`.
- set  input  1  interface set request, level-sensitive, active-high.
- reset  input  1  interface clear request, level-sensitive, active-high. This is functional, not the system reset.
- bit  output  1  latched output bit to the pin; registered.

Behaviour:
- Power-up value of `bit` is DEFAULT. Synchroniser flops power up to 0.
- System reset: at a rising edge with rst_n=0, `bit` becomes DEFAULT and all synchroniser flops clear to 0. This overrides `set` and `reset`.
- Internal sampled controls:
  - s_eff and r_eff are `set` and `reset` delayed by SYNC_STAGES flops each.
  - With SYNC_STAGES=0, s_eff=set and r_eff=reset.
- Update rule at each rising edge with rst_n=1:
  - r_eff=1: `bit` becomes 0. Clear wins when both are high.
  - else s_eff=1: `bit` becomes 1.
  - else: `bit` holds its value.
- Latency: `bit` reflects a control change 1+SYNC_STAGES rising edges after the control is first sampled high.
- Level semantics, not edge:
  - Holding `set` high re-asserts `bit` every cycle.
  - If `reset` pulses while `set` is still high, `bit` is 0 for exactly one cycle (the cycle after the pulse is sampled), then returns to 1 while `set` remains high.
- `bit` has no combinational path from any input; it is a direct flop output.
- Releasing rst_n: first update on the edge after rst_n is sampled high. Synchroniser pipelines restart from 0.
- Single-cycle pulses of one clock period must be captured: no minimum pulse width beyond one sampled edge.
- The synchroniser pipeline depth is identical on both control paths so their relative timing is preserved.

Test Plan:
- Reset default: DEFAULT=0, rst_n=0 for 2 cycles with set=1 -> bit=0 throughout. DEFAULT=1 repeated -> bit=1.
- Set pulse: SYNC_STAGES=0, bit=0, set=1 for one cycle -> bit=1 after that edge, and stays 1 for ≥3 idle cycles.
- Clear pulse: from bit=1, reset=1 for one cycle -> bit=0 after that edge, and holds 0 afterwards.
- Clear priority / level set: set=1 held, then reset=1 for one cycle -> bit=0 for exactly one cycle, then 1. Then set=0 -> bit stays 1.
- Synchroniser latency: SYNC_STAGES=2, set pulse at edge N -> bit rises after edge N+2. Same check for a reset pulse.
- Mid-operation reset: bit=1 with set held, assert rst_n=0 one cycle (DEFAULT=0) -> bit=0 that edge. Release rst_n -> bit=1 again after 1+SYNC_STAGES edges.

Source files
------------

// File: rtl/flipflop_out_cell.sv
// Single-bit set/clear output latch for one pin, with optional input synchronisers.
// The pin is named out_bit because "bit" is a reserved word in SystemVerilog.
module flipflop_out_cell #(
    parameter int DEFAULT     = 0,
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic reset,
    output logic out_bit
);

    localparam logic DEF_BIT = (DEFAULT != 0);

    logic s_eff;
    logic r_eff;

    if (SYNC_STAGES == 0) begin : g_direct
        assign s_eff = set;
        assign r_eff = reset;
    end else begin : g_sync
        // Both controls share one depth so their relative timing survives the crossing.
        logic [SYNC_STAGES-1:0] set_sync_q = '0;
        logic [SYNC_STAGES-1:0] rst_sync_q = '0;
        logic [SYNC_STAGES-1:0] set_sync_d;
        logic [SYNC_STAGES-1:0] rst_sync_d;

        always_comb begin
            set_sync_d    = set_sync_q;
            rst_sync_d    = rst_sync_q;
            set_sync_d[0] = set;
            rst_sync_d[0] = reset;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                set_sync_d[i] = set_sync_q[i-1];
                rst_sync_d[i] = rst_sync_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                set_sync_q <= '0;
                rst_sync_q <= '0;
            end else begin
                set_sync_q <= set_sync_d;
                rst_sync_q <= rst_sync_d;
            end
        end

        assign s_eff = set_sync_q[SYNC_STAGES-1];
        assign r_eff = rst_sync_q[SYNC_STAGES-1];
    end

    logic out_q = DEF_BIT;
    logic out_d;

    // Clear has priority over set; with neither asserted the bit holds.
    always_comb begin
        out_d = out_q;
        if (r_eff) begin
            out_d = 1'b0;
        end else if (s_eff) begin
            out_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= DEF_BIT;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_bit = out_q;

endmodule

// File: tb/tb_flipflop_out_cell.sv
// Directed bench for flipflop_out_cell: three instances cover DEFAULT=0/1 and SYNC_STAGES=0/2.
module tb_flipflop_out_cell;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic set = 1'b0;
    logic reset = 1'b0;
    logic b0;
    logic b1;
    logic b2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    flipflop_out_cell #(.DEFAULT(0), .SYNC_STAGES(0)) u_d0_s0 (
        .clk(clk), .rst_n(rst_n), .set(set), .reset(reset), .out_bit(b0));
    flipflop_out_cell #(.DEFAULT(1), .SYNC_STAGES(0)) u_d1_s0 (
        .clk(clk), .rst_n(rst_n), .set(set), .reset(reset), .out_bit(b1));
    flipflop_out_cell #(.DEFAULT(0), .SYNC_STAGES(2)) u_d0_s2 (
        .clk(clk), .rst_n(rst_n), .set(set), .reset(reset), .out_bit(b2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL powerup_d0 got=%b exp=0", b0); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL powerup_d1 got=%b exp=1", b1); end
        rst_n = 1'b0; set = 1'b1; reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL reset_d0 cyc%0d got=%b exp=0", i, b0); end
            checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL reset_d1 cyc%0d got=%b exp=1", i, b1); end
            checks++; if (b2 !== 1'b0) begin errors++; $display("FAIL reset_s2 cyc%0d got=%b exp=0", i, b2); end
        end
        rst_n = 1'b1; set = 1'b0;
        tick();
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL idle_d0 got=%b exp=0", b0); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL idle_d1 got=%b exp=1", b1); end
        tick();
    endtask

    task automatic test_set_pulse();
        set = 1'b1;
        tick();
        set = 1'b0;
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL set_edge_s0 got=%b exp=1", b0); end
        checks++; if (b2 !== 1'b0) begin errors++; $display("FAIL set_edge_s2 got=%b exp=0", b2); end
        tick();
        checks++; if (b2 !== 1'b0) begin errors++; $display("FAIL set_n1_s2 got=%b exp=0", b2); end
        tick();
        checks++; if (b2 !== 1'b1) begin errors++; $display("FAIL set_n2_s2 got=%b exp=1", b2); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL set_hold_s0 cyc%0d got=%b exp=1", i, b0); end
            tick();
        end
        checks++; if (b2 !== 1'b1) begin errors++; $display("FAIL set_hold_s2 got=%b exp=1", b2); end
    endtask

    task automatic test_clear_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL clr_edge_s0 got=%b exp=0", b0); end
        checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL clr_edge_d1 got=%b exp=0", b1); end
        checks++; if (b2 !== 1'b1) begin errors++; $display("FAIL clr_edge_s2 got=%b exp=1", b2); end
        tick();
        checks++; if (b2 !== 1'b1) begin errors++; $display("FAIL clr_n1_s2 got=%b exp=1", b2); end
        tick();
        checks++; if (b2 !== 1'b0) begin errors++; $display("FAIL clr_n2_s2 got=%b exp=0", b2); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL clr_hold_s0 cyc%0d got=%b exp=0", i, b0); end
            tick();
        end
    endtask

    task automatic test_clear_priority();
        set = 1'b1;
        tick();
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL lvl_set_e1 got=%b exp=1", b0); end
        tick();
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL lvl_set_e2 got=%b exp=1", b0); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL prio_clr_e3 got=%b exp=0", b0); end
        checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL prio_clr_d1_e3 got=%b exp=0", b1); end
        tick();
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL prio_back_e4 got=%b exp=1", b0); end
        checks++; if (b2 !== 1'b1) begin errors++; $display("FAIL prio_s2_e4 got=%b exp=1", b2); end
        tick();
        checks++; if (b2 !== 1'b0) begin errors++; $display("FAIL prio_s2_e5 got=%b exp=0", b2); end
        set = 1'b0;
        tick();
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL release_e6 got=%b exp=1", b0); end
        checks++; if (b2 !== 1'b1) begin errors++; $display("FAIL prio_s2_e6 got=%b exp=1", b2); end
        tick();
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL release_e7 got=%b exp=1", b0); end
    endtask

    task automatic test_mid_reset();
        set = 1'b1;
        tick(); tick(); tick();
        checks++; if (b2 !== 1'b1) begin errors++; $display("FAIL pre_rst_s2 got=%b exp=1", b2); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL mid_rst_s0 got=%b exp=0", b0); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL mid_rst_d1 got=%b exp=1", b1); end
        checks++; if (b2 !== 1'b0) begin errors++; $display("FAIL mid_rst_s2 got=%b exp=0", b2); end
        tick();
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL rel1_s0 got=%b exp=1", b0); end
        checks++; if (b2 !== 1'b0) begin errors++; $display("FAIL rel1_s2 got=%b exp=0", b2); end
        tick();
        checks++; if (b2 !== 1'b0) begin errors++; $display("FAIL rel2_s2 got=%b exp=0", b2); end
        tick();
        checks++; if (b2 !== 1'b1) begin errors++; $display("FAIL rel3_s2 got=%b exp=1", b2); end
        set = 1'b0;
    endtask

    initial begin
        test_reset();
        test_set_pulse();
        test_clear_pulse();
        test_clear_priority();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
